seg7_scan_mux: RTL

Parametrised, double-buffered seven-segment scan multiplexer for an N-digit common-anode display. It takes packed hex nibbles, per-digit decimal-point and blank masks, and a load strobe. It time-multiplexes the digits onto shared active-low segment lines and active-low anode lines. New data is committed only at frame boundaries, so the display never tears. It sits directly at the board pins, replacing fixed-pattern display drivers, and is fed by any datapath that needs to show values.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_hex_decode.sv | 15 +
 rtl/seg7_scan_mux.sv | 111 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan multiplexer:
// hex-to-segment table (active low, bit7 = dp), blank pattern and digit record.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Entry n is the active-low a..g pattern for hex digit n, dp bit held high.
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef struct packed {
    logic [3:0] nib;
    logic       dp;
    logic       blank;
  } digit_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble + decimal point to active-low segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_LUT[nib];
    if (dp) seg[7] = 1'b0;
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Double-buffered N-digit common-anode scan multiplexer; new data commits only
// at frame boundaries. Optional anode dimming is built when SEG7_DIM_EN is defined.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digit_data_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    load_i,
  input  logic [3:0]              brightness_i,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_o
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         prescaler;
  logic [IW-1:0]         idx;
  logic                  pend_valid;
  digit_t                pend_q    [NUM_DIGITS];
  digit_t                act_q     [NUM_DIGITS];
  digit_t                in_digits [NUM_DIGITS];
  digit_t                cur;
  logic                  tick;
  logic                  frame_edge;
  logic                  anode_en;
  logic [7:0]            dec_seg;
  logic [NUM_DIGITS-1:0] an_onehot;

  assign tick       = (prescaler == PRE_LAST);
  assign frame_edge = tick && (idx == IDX_LAST);
  assign cur        = act_q[idx];
  assign an_onehot  = NUM_DIGITS'(1) << idx;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      in_digits[i] = '{nib: digit_data_i[4*i +: 4], dp: dp_i[i], blank: blank_i[i]};
    end
  end

  seg7_hex_decode u_dec (
    .nib (cur.nib),
    .dp  (cur.dp),
    .seg (dec_seg)
  );

`ifdef SEG7_DIM_EN
  logic [3:0] bright_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    bright_q <= '0;
    else if (tick) bright_q <= brightness_i;
  end

  // Anode on for the first (bright+1)/16 of the slot; level 15 means the whole slot.
  assign anode_en = (bright_q == 4'hF) ||
                    (32'(prescaler) < (32'(bright_q) + 32'd1) * 32'(SCAN_DIV / 16));
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness_i;
  assign anode_en          = 1'b1;
`endif

  // load_i has no ready: every asserted cycle is accepted and overwrites pending.
  // Ordering below lets a same-cycle load land in pending after the commit reads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler  <= '0;
      idx        <= '0;
      pend_valid <= 1'b0;
      seg        <= SEG_OFF;
      an         <= '1;
      frame_o    <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
      end
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      frame_o <= frame_edge;

      if (frame_edge && pend_valid) begin
        act_q      <= pend_q;
        pend_valid <= 1'b0;
      end
      if (load_i) begin
        pend_q     <= in_digits;
        pend_valid <= 1'b1;
      end

      if (cur.blank) begin
        an  <= '1;
        seg <= SEG_OFF;
      end else begin
        an  <= anode_en ? ~an_onehot : '1;
        seg <= dec_seg;
      end
    end
  end

endmodule
